snake_move_ctrl: RTL and testbench



---
 rtl/snake_move_ctrl.sv | 172 +++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: advances the head one grid cell per
// game-tick toggle, arbitrates direction keys, detects wall hits and
// tracks snake length. All outputs are registered.
module snake_move_ctrl #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 63
) (
  input  logic       CLK_40M,
  input  logic       RST,
  input  logic       tick_tgl,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       eat,
  input  logic       restart,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [1:0] dir,
  output logic [5:0] length,
  output logic       step_pulse,
  output logic       game_over,
  output logic       running
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  localparam logic [5:0] SX    = 6'(START_X);
  localparam logic [4:0] SY    = 5'(START_Y);
  localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);
  localparam logic [5:0] L_INI = 6'(INIT_LEN);
  localparam logic [5:0] L_MAX = 6'(MAX_LEN);

  state_t     state_q, state_d;
  logic [5:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] pend_q, pend_d;
  logic [5:0] len_q, len_d;
  logic       pulse_q, pulse_d;
  logic       over_q, run_q;
  logic       tick_q;

  logic       step_evt;
  logic       key_any;
  logic [1:0] key_dir;
  logic       wall;
  logic [5:0] nx;
  logic [4:0] ny;

  // Delay the toggle by one cycle; any level change is one step event.
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) tick_q <= 1'b0;
    else     tick_q <= tick_tgl;
  end

  assign step_evt = tick_tgl ^ tick_q;

  // Fixed-priority key arbitration: up > down > left > right.
  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    key_dir = D_RIGHT;
    if      (key_up)   key_dir = D_UP;
    else if (key_down) key_dir = D_DOWN;
    else if (key_left) key_dir = D_LEFT;
  end

  // Candidate next head cell in the pending direction and its wall check.
  always_comb begin
    nx   = x_q;
    ny   = y_q;
    wall = 1'b0;
    case (pend_q)
      D_UP:    begin wall = (y_q == 5'd0);  ny = y_q - 5'd1; end
      D_DOWN:  begin wall = (y_q == Y_MAX); ny = y_q + 5'd1; end
      D_LEFT:  begin wall = (x_q == 6'd0);  nx = x_q - 6'd1; end
      default: begin wall = (x_q == X_MAX); nx = x_q + 6'd1; end
    endcase
  end

  // Game FSM next-state: moves, key latching, growth, restart override.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    len_d   = len_q;
    pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // First key starts the game; no reversal check from standstill.
        if (key_any) begin
          state_d = S_RUN;
          dir_d   = key_dir;
          pend_d  = key_dir;
        end
      end
      S_RUN: begin
        // Opposite directions differ only in bit 0.
        if (key_any && (key_dir != (dir_q ^ 2'b01)))
          pend_d = key_dir;
        if (eat)
          len_d = (len_q >= L_MAX) ? L_MAX : len_q + 6'd1;
        if (step_evt) begin
          dir_d = pend_q;
          if (wall) begin
            state_d = S_OVER;
          end else begin
            x_d     = nx;
            y_d     = ny;
            pulse_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (restart) begin
      state_d = S_IDLE;
      x_d     = SX;
      y_d     = SY;
      dir_d   = D_RIGHT;
      pend_d  = D_RIGHT;
      len_d   = L_INI;
      pulse_d = 1'b0;
    end
  end

  // State and output registers; status flags follow the next state.
  always_ff @(posedge CLK_40M or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      x_q     <= SX;
      y_q     <= SY;
      dir_q   <= D_RIGHT;
      pend_q  <= D_RIGHT;
      len_q   <= L_INI;
      pulse_q <= 1'b0;
      over_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      pulse_q <= pulse_d;
      over_q  <= (state_d == S_OVER);
      run_q   <= (state_d == S_RUN);
    end
  end

  assign head_x     = x_q;
  assign head_y     = y_q;
  assign dir        = dir_q;
  assign length     = len_q;
  assign step_pulse = pulse_q;
  assign game_over  = over_q;
  assign running    = run_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl: expected head positions are queued
// when a tick is driven and compared when step_pulse appears.
module tb_snake_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgl = 1'b0;
  logic       ku = 1'b0, kd = 1'b0, kl = 1'b0, kr = 1'b0;
  logic       eat = 1'b0;
  logic       rs  = 1'b0;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic [5:0] length;
  logic       step_pulse, game_over, running;

  int checks = 0;
  int errors = 0;

  typedef struct {int x; int y; int d;} exp_t;
  exp_t sb[$];

  snake_move_ctrl dut (
    .CLK_40M   (clk),
    .RST       (rst),
    .tick_tgl  (tgl),
    .key_up    (ku),
    .key_down  (kd),
    .key_left  (kl),
    .key_right (kr),
    .eat       (eat),
    .restart   (rs),
    .head_x    (head_x),
    .head_y    (head_y),
    .dir       (dir),
    .length    (length),
    .step_pulse(step_pulse),
    .game_over (game_over),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // keys = {up, down, left, right}, held for one clock edge
  task automatic pulse_keys(input logic [3:0] k);
    @(negedge clk); {ku, kd, kl, kr} = k;
    @(negedge clk); {ku, kd, kl, kr} = 4'b0;
  endtask

  task automatic pulse_eat(input int n);
    @(negedge clk); eat = 1'b1;
    repeat (n) @(negedge clk);
    eat = 1'b0;
  endtask

  // Toggle the tick (optionally with keys in the same cycle). If mv, the
  // head must reach (ex,ey) with dir ed on a single one-cycle step_pulse;
  // otherwise no pulse may appear and the head must sit at (ex,ey).
  task automatic step(input logic [3:0] k, input int ex, input int ey,
                      input int ed, input bit mv);
    exp_t e;
    int   seen;
    if (mv) sb.push_back('{ex, ey, ed});
    @(negedge clk); tgl = ~tgl; {ku, kd, kl, kr} = k;
    @(negedge clk); {ku, kd, kl, kr} = 4'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (step_pulse) begin
        seen++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("step_x",   int'(head_x), e.x);
          chk("step_y",   int'(head_y), e.y);
          chk("step_dir", int'(dir),    e.d);
        end
      end
      @(negedge clk);
    end
    chk("step_pulse_count", seen, mv ? 1 : 0);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
    if (!mv) begin
      chk("hold_x",   int'(head_x), ex);
      chk("hold_y",   int'(head_y), ey);
      chk("hold_dir", int'(dir),    ed);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_x", int'(head_x), 20);
    chk("rst_y", int'(head_y), 15);
    chk("rst_dir", int'(dir), 3);
    chk("rst_len", int'(length), 3);
    chk("rst_running", int'(running), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_pulse", int'(step_pulse), 0);

    // Ticks in IDLE are ignored
    step(4'b0000, 20, 15, 3, 1'b0);
    chk("idle_running", int'(running), 0);

    // Start heading right, three steps
    pulse_keys(4'b0001);
    chk("start_running", int'(running), 1);
    chk("start_dir", int'(dir), 3);
    step(4'b0000, 21, 15, 3, 1'b1);
    step(4'b0000, 22, 15, 3, 1'b1);
    step(4'b0000, 23, 15, 3, 1'b1);

    // Reversal key ignored
    pulse_keys(4'b0010);
    step(4'b0000, 24, 15, 3, 1'b1);

    // up + left together: up wins
    pulse_keys(4'b1010);
    step(4'b0000, 24, 14, 0, 1'b1);

    // Turn right, then key_down coincident with the tick
    pulse_keys(4'b0001);
    step(4'b0000, 25, 14, 3, 1'b1);
    step(4'b0100, 26, 14, 3, 1'b1);
    step(4'b0000, 26, 15, 1, 1'b1);

    // Length saturation
    pulse_eat(61);
    chk("len_sat", int'(length), 63);
    pulse_eat(1);
    chk("len_sat_hold", int'(length), 63);

    // Run into the right wall
    pulse_keys(4'b0001);
    for (int x = 27; x <= 39; x++) step(4'b0000, x, 15, 3, 1'b1);
    step(4'b0000, 39, 15, 3, 1'b0);
    chk("wall_over", int'(game_over), 1);
    chk("wall_running", int'(running), 0);
    step(4'b0000, 39, 15, 3, 1'b0);
    pulse_eat(1);
    chk("over_len_frozen", int'(length), 63);
    chk("over_still", int'(game_over), 1);

    // Restart
    @(negedge clk); rs = 1'b1;
    @(negedge clk); rs = 1'b0;
    chk("rs_over", int'(game_over), 0);
    chk("rs_running", int'(running), 0);
    chk("rs_x", int'(head_x), 20);
    chk("rs_y", int'(head_y), 15);
    chk("rs_dir", int'(dir), 3);
    chk("rs_len", int'(length), 3);

    // eat in IDLE
    pulse_eat(1);
    chk("idle_eat_len", int'(length), 3);

    // Asynchronous reset mid-run, toggle during reset ignored
    pulse_keys(4'b0001);
    step(4'b0000, 21, 15, 3, 1'b1);
    pulse_eat(2);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("arst_x", int'(head_x), 20);
    chk("arst_len", int'(length), 3);
    chk("arst_running", int'(running), 0);
    chk("arst_pulse", int'(step_pulse), 0);
    tgl = ~tgl;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_x", int'(head_x), 20);
    chk("post_rst_running", int'(running), 0);
    chk("post_rst_pulse", int'(step_pulse), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
